// File: rtl/mcalu_sched_pkg.sv
// mcalu_sched_pkg: opcodes, widths and station entry types shared by the mcalu scheduler
package mcalu_sched_pkg;
  localparam int TAG_W = 6;
  localparam int ROBID_W = 7;
  localparam int OP_W = 5;
  localparam logic [OP_W-1:0] OP_MUL = 5'd0;
  localparam logic [OP_W-1:0] OP_MULH = 5'd1;
  localparam logic [OP_W-1:0] OP_MULHSU = 5'd2;
  localparam logic [OP_W-1:0] OP_MULHU = 5'd3;
  localparam logic [OP_W-1:0] OP_DIV = 5'd4;
  localparam logic [OP_W-1:0] OP_DIVU = 5'd5;
  localparam logic [OP_W-1:0] OP_REM = 5'd6;
  localparam logic [OP_W-1:0] OP_REMU = 5'd7;
  localparam logic [OP_W-1:0] OP_ADD = 5'd8;
  localparam logic [OP_W-1:0] OP_SUB = 5'd9;
  localparam logic [OP_W-1:0] OP_AND = 5'd10;
  localparam logic [OP_W-1:0] OP_OR = 5'd11;
  localparam logic [OP_W-1:0] OP_XOR = 5'd12;
  typedef struct packed {
    logic rdy;
    logic [TAG_W-1:0] tag;
    logic [31:0] val;
  } opnd_t;
  typedef struct packed {
    logic [OP_W-1:0] op;
    logic [ROBID_W-1:0] robid;
    logic [TAG_W-1:0] rd;
    opnd_t a;
    opnd_t b;
  } entry_t;
  function automatic opnd_t wake(opnd_t o, logic v, logic [TAG_W-1:0] t, logic [31:0] d);
    if (v && !o.rdy && o.tag == t) begin
      o.rdy = 1'b1;
      o.val = d;
    end
    return o;
  endfunction
endpackage

// File: rtl/mcalu_sched_pick.sv
// mcalu_sched_pick: oldest-ready priority encoder (lowest index wins)
module mcalu_sched_pick #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  rdy,
  output logic [IW-1:0] idx,
  output logic          found
);
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) idx = rdy[i] ? IW'(i) : idx;
  end
  assign found = |rdy;
endmodule

// File: rtl/mcalu_sched.sv
// mcalu_sched: collapsing age-ordered reservation station feeding the multi-cycle ALU
module mcalu_sched #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             disp_valid,
  input  logic [4:0]       disp_op,
  input  logic [6:0]       disp_robid,
  input  logic [TAG_W-1:0] disp_rd,
  input  logic             disp_op1_rdy,
  input  logic [TAG_W-1:0] disp_op1_tag,
  input  logic [31:0]      disp_op1,
  input  logic             disp_op2_rdy,
  input  logic [TAG_W-1:0] disp_op2_tag,
  input  logic [31:0]      disp_op2,
  output logic             sched_stall,
  input  logic             wb_valid,
  input  logic [TAG_W-1:0] wb_rd,
  input  logic [31:0]      wb_result,
  output logic             exers_mcalu_issue,
  output logic [4:0]       exers_mcalu_op,
  output logic [6:0]       exers_robid,
  output logic [TAG_W-1:0] exers_rd,
  output logic [31:0]      exers_op1,
  output logic [31:0]      exers_op2,
  input  logic             mcalu_stall,
  input  logic             rob_flush
);
  import mcalu_sched_pkg::*;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);
  entry_t q [DEPTH];
  entry_t nq [DEPTH];
  entry_t ne, sel;
  logic [CW-1:0] cnt, ncnt;
  logic [DEPTH-1:0] rdy;
  logic [IW-1:0] idx;
  logic found, fire, disp_ok;
  always_comb begin
    for (int i = 0; i < DEPTH; i++) rdy[i] = CW'(i) < cnt && q[i].a.rdy && q[i].b.rdy;
  end
  mcalu_sched_pick #(.N(DEPTH)) u_pick (.rdy(rdy), .idx(idx), .found(found));
  assign sched_stall = cnt == CW'(DEPTH);
  assign fire = found & ~mcalu_stall;
  assign disp_ok = disp_valid & ~sched_stall;
  assign sel = found ? q[idx] : '0;
  assign exers_mcalu_issue = found;
  assign exers_mcalu_op = sel.op;
  assign exers_robid = sel.robid;
  assign exers_rd = sel.rd;
  assign exers_op1 = sel.a.val;
  assign exers_op2 = sel.b.val;
  always_comb begin
    ne.op = disp_op;
    ne.robid = disp_robid;
    ne.rd = disp_rd;
    ne.a = wake({disp_op1_rdy, disp_op1_tag, disp_op1}, wb_valid, wb_rd, wb_result);
    ne.b = wake({disp_op2_rdy, disp_op2_tag, disp_op2}, wb_valid, wb_rd, wb_result);
  end
  // collapse first, then wake, so entries moving down keep this cycle's broadcast
  always_comb begin
    nq = q;
    for (int i = 0; i < DEPTH - 1; i++) nq[i] = (fire && i >= int'(idx)) ? q[i + 1] : q[i];
    for (int i = 0; i < DEPTH; i++) begin
      nq[i].a = wake(nq[i].a, wb_valid, wb_rd, wb_result);
      nq[i].b = wake(nq[i].b, wb_valid, wb_rd, wb_result);
      nq[i] = (disp_ok && CW'(i) == cnt - CW'(fire)) ? ne : nq[i];
    end
    ncnt = cnt - CW'(fire) + CW'(disp_ok);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst || rob_flush) begin
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
    end else begin
      cnt <= ncnt;
      q <= nq;
    end
  end
endmodule
